// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, receive FSM encoding and the
// oversample divider calculation.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PAR,
        ST_STOP
    } rx_state_t;

    // Clocks per 16x oversample tick
    function automatic int uart_div(input int clk_hz, input int baud);
        return clk_hz / (baud * 16);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead register-array FIFO; the head entry is always visible on dout.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Extra pointer MSB separates full (MSBs differ) from empty (pointers equal)
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign count   = wr_ptr - rd_ptr;
    assign dout    = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// RS232 receiver: 2-flop synchroniser, 16x oversample tick, framing FSM with
// optional parity, buffered by a show-ahead FIFO with sticky error flags.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_HZ    = 50_000_000,
    parameter int BAUD      = 115_200,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int DEPTH     = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rx,
    input  logic                     rd_en,
    output logic [DATA_BITS-1:0]     rd_data,
    output logic                     rd_valid,
    output logic [$clog2(DEPTH):0]   count,
    input  logic                     err_clr,
    output logic                     frame_err,
    output logic                     parity_err,
    output logic                     overrun
);
    localparam int DIV   = uart_div(CLK_HZ, BAUD);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

    if (DIV < 1) begin : g_div_check
        $error("uart_rx_fifo: CLK_HZ too low for BAUD, divider below 1");
    end

    function automatic logic par_exp(input logic [DATA_BITS-1:0] d);
        return (^d) ^ (PARITY == PAR_ODD);
    endfunction

    logic                  rx_p0;
    logic                  rx_p1;
    logic [DIV_W-1:0]      div_cnt;
    logic                  tick;
    rx_state_t             state;
    logic [3:0]            tick_cnt;
    logic [2:0]            bit_cnt;
    logic [DATA_BITS-1:0]  shreg;
    logic                  perr;
    logic                  stop_sample;
    logic                  push;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic                  pop_ok;

    // Stage p0/p1: metastability synchroniser, idles high
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_p0 <= 1'b1;
            rx_p1 <= 1'b1;
        end else begin
            rx_p0 <= rx;
            rx_p1 <= rx_p0;
        end
    end

    assign tick = (div_cnt == DIV_W'(DIV - 1));

    always_ff @(posedge clk) begin
        if (rst)       div_cnt <= '0;
        else if (tick) div_cnt <= '0;
        else           div_cnt <= div_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            perr     <= 1'b0;
        end else if (tick) begin
            case (state)
                ST_IDLE: begin
                    if (!rx_p1) begin
                        state    <= ST_START;
                        tick_cnt <= '0;
                        perr     <= 1'b0;
                    end
                end
                ST_START: begin
                    if (tick_cnt == 4'd7) begin
                        tick_cnt <= '0;
                        bit_cnt  <= '0;
                        state    <= rx_p1 ? ST_IDLE : ST_DATA;
                    end else begin
                        tick_cnt <= tick_cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    tick_cnt <= tick_cnt + 1'b1;
                    if (tick_cnt == 4'd15) begin
                        shreg   <= {rx_p1, shreg[DATA_BITS-1:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'(DATA_BITS - 1))
                            state <= (PARITY != PAR_NONE) ? ST_PAR : ST_STOP;
                    end
                end
                ST_PAR: begin
                    tick_cnt <= tick_cnt + 1'b1;
                    if (tick_cnt == 4'd15) begin
                        perr  <= (rx_p1 != par_exp(shreg));
                        state <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    tick_cnt <= tick_cnt + 1'b1;
                    if (tick_cnt == 4'd15) state <= ST_IDLE;
                end
                default: begin
                    state    <= ST_IDLE;
                    tick_cnt <= '0;
                end
            endcase
        end
    end

    assign stop_sample = (state == ST_STOP) && tick && (tick_cnt == 4'd15);
    assign push        = stop_sample && rx_p1 && !perr;
    assign pop_ok      = rd_en && !fifo_empty;

    // Error flags: clear wins over any set in the same cycle
    always_ff @(posedge clk) begin
        if (rst || err_clr) begin
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (stop_sample && !rx_p1)               frame_err  <= 1'b1;
            if (stop_sample && rx_p1 && perr)        parity_err <= 1'b1;
            if (push && fifo_full && !pop_ok)        overrun    <= 1'b1;
        end
    end

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (rd_en),
        .din   (shreg),
        .dout  (rd_data),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (count)
    );

    assign rd_valid = !fifo_empty;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: an 8N1 and an 8E1 receiver share clock and reset,
// each compared against a queue-based model of the received byte stream.
module tb_uart_rx_fifo;
    localparam int CLK_HZ = 1_600_000;
    localparam int BAUD   = 100_000;
    localparam int DEPTH  = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       err_clr = 1'b0;

    logic       rx_n = 1'b1, rd_en_n = 1'b0;
    logic [7:0] rd_data_n;
    logic       rd_valid_n, fe_n, pe_n, ov_n;
    logic [2:0] count_n;

    logic       rx_e = 1'b1, rd_en_e = 1'b0;
    logic [7:0] rd_data_e;
    logic       rd_valid_e, fe_e, pe_e, ov_e;
    logic [2:0] count_e;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] q0[$];
    logic [7:0] q1[$];
    bit m_fe[2], m_pe[2], m_ov[2];

    always #5 clk = ~clk;

    uart_rx_fifo #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(0), .DEPTH(DEPTH)) dut_n (
        .clk(clk), .rst(rst), .rx(rx_n), .rd_en(rd_en_n), .rd_data(rd_data_n),
        .rd_valid(rd_valid_n), .count(count_n), .err_clr(err_clr),
        .frame_err(fe_n), .parity_err(pe_n), .overrun(ov_n));

    uart_rx_fifo #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(2), .DEPTH(DEPTH)) dut_e (
        .clk(clk), .rst(rst), .rx(rx_e), .rd_en(rd_en_e), .rd_data(rd_data_e),
        .rd_valid(rd_valid_e), .count(count_e), .err_clr(err_clr),
        .frame_err(fe_e), .parity_err(pe_e), .overrun(ov_e));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_line(input int ch, input logic v);
        if (ch == 1) rx_e = v; else rx_n = v;
    endtask

    task automatic set_rden(input int ch, input logic v);
        if (ch == 1) rd_en_e = v; else rd_en_n = v;
    endtask

    function automatic int msize(input int ch);
        return (ch == 1) ? q1.size() : q0.size();
    endfunction

    function automatic logic [7:0] mfront(input int ch);
        return (ch == 1) ? q1[0] : q0[0];
    endfunction

    task automatic mpop(input int ch);
        if (ch == 1) void'(q1.pop_front()); else void'(q0.pop_front());
    endtask

    task automatic mpush(input int ch, input logic [7:0] d);
        if (ch == 1) q1.push_back(d); else q0.push_back(d);
    endtask

    task automatic check_state(input string tag, input int ch);
        logic v, fe, pe, ov;
        logic [7:0] d;
        logic [2:0] c;
        v  = (ch == 1) ? rd_valid_e : rd_valid_n;
        d  = (ch == 1) ? rd_data_e  : rd_data_n;
        c  = (ch == 1) ? count_e    : count_n;
        fe = (ch == 1) ? fe_e : fe_n;
        pe = (ch == 1) ? pe_e : pe_n;
        ov = (ch == 1) ? ov_e : ov_n;
        check($sformatf("%s_valid%0d", tag, ch), 32'(v), 32'(msize(ch) != 0));
        check($sformatf("%s_count%0d", tag, ch), 32'(c), 32'(msize(ch)));
        if (msize(ch) != 0) check($sformatf("%s_data%0d", tag, ch), 32'(d), 32'(mfront(ch)));
        check($sformatf("%s_fe%0d", tag, ch), 32'(fe), 32'(m_fe[ch]));
        check($sformatf("%s_pe%0d", tag, ch), 32'(pe), 32'(m_pe[ch]));
        check($sformatf("%s_ov%0d", tag, ch), 32'(ov), 32'(m_ov[ch]));
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drives one frame; with pop_at>=0 rd_en is held for the posedge after negedge pop_at
    task automatic send_frame(input int ch, input logic [7:0] d, input bit par_ok,
                              input bit stop_bit, input int pop_at);
        logic bits[11];
        int nb = 0;
        int k = 0;
        bit did_pop = 0;
        logic [7:0] pop_data = '0;
        bits[nb++] = 1'b0;
        for (int i = 0; i < 8; i++) bits[nb++] = d[i];
        if (ch == 1) bits[nb++] = par_ok ? ^d : ~(^d);
        bits[nb++] = stop_bit;
        for (int b = 0; b < nb; b++) begin
            for (int c = 0; c < 16; c++) begin
                if (c == 0) set_line(ch, bits[b]);
                if (k == pop_at) begin
                    did_pop  = (msize(ch) != 0);
                    pop_data = (ch == 1) ? rd_data_e : rd_data_n;
                    set_rden(ch, 1'b1);
                end else begin
                    set_rden(ch, 1'b0);
                end
                @(negedge clk);
                k++;
            end
        end
        set_rden(ch, 1'b0);
        set_line(ch, 1'b1);
        if (did_pop) begin
            check("pop_on_push_data", 32'(pop_data), 32'(mfront(ch)));
            mpop(ch);
        end
        if (!stop_bit)                  m_fe[ch] = 1'b1;
        else if (ch == 1 && !par_ok)    m_pe[ch] = 1'b1;
        else if (msize(ch) == DEPTH)    m_ov[ch] = 1'b1;
        else                            mpush(ch, d);
        idle(2);
    endtask

    task automatic pop_one(input int ch);
        if (msize(ch) != 0)
            check($sformatf("pop_data%0d", ch), 32'((ch == 1) ? rd_data_e : rd_data_n), 32'(mfront(ch)));
        set_rden(ch, 1'b1);
        @(negedge clk);
        set_rden(ch, 1'b0);
        if (msize(ch) != 0) mpop(ch);
    endtask

    task automatic clear_errs();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        for (int ch = 0; ch < 2; ch++) begin
            m_fe[ch] = 0; m_pe[ch] = 0; m_ov[ch] = 0;
        end
    endtask

    task automatic reset_model();
        q0.delete();
        q1.delete();
        for (int ch = 0; ch < 2; ch++) begin
            m_fe[ch] = 0; m_pe[ch] = 0; m_ov[ch] = 0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
        $fatal(1);
    end

    initial begin
        reset_model();
        idle(3);
        check_state("reset", 0);
        check_state("reset", 1);
        check("reset_data0", 32'(rd_data_n), 32'h0);
        rst = 1'b0;
        idle(20);

        // 8N1 single frame
        send_frame(0, 8'hA5, 1, 1, -1);
        check("a5_valid", 32'(rd_valid_n), 32'h1);
        check("a5_data", 32'(rd_data_n), 32'hA5);
        check("a5_count", 32'(count_n), 32'h1);
        pop_one(0);
        check("a5_after_pop", 32'(rd_valid_n), 32'h0);

        // Even parity: good then bad parity bit
        send_frame(1, 8'h03, 1, 1, -1);
        check_state("par_good", 1);
        send_frame(1, 8'h03, 0, 1, -1);
        check_state("par_bad", 1);
        check("par_err_set", 32'(pe_e), 32'h1);
        clear_errs();
        check("par_err_clr", 32'(pe_e), 32'h0);
        pop_one(1);

        // Framing error, then a short glitch
        send_frame(0, 8'h55, 1, 0, -1);
        check_state("frame", 0);
        check("frame_err_set", 32'(fe_n), 32'h1);
        clear_errs();
        rx_n = 1'b0;
        idle(4);
        rx_n = 1'b1;
        idle(40);
        check_state("glitch", 0);

        // Overrun
        for (int i = 1; i <= 5; i++) send_frame(0, 8'(i), 1, 1, -1);
        check_state("ovr", 0);
        check("ovr_count", 32'(count_n), 32'h4);
        check("ovr_flag", 32'(ov_n), 32'h1);
        for (int i = 1; i <= 4; i++) begin
            check("ovr_read", 32'(rd_data_n), 32'(i));
            pop_one(0);
        end
        clear_errs();

        // Full FIFO with rd_en on the push cycle
        for (int i = 0; i < 4; i++) send_frame(0, 8'(8'h10 + i), 1, 1, -1);
        send_frame(0, 8'h14, 1, 1, 154);
        check_state("fullpop", 0);
        check("fullpop_count", 32'(count_n), 32'h4);
        check("fullpop_ovr", 32'(ov_n), 32'h0);
        while (msize(0) != 0) pop_one(0);

        // Reset in the middle of a frame
        send_frame(0, 8'h77, 1, 1, -1);
        send_frame(1, 8'h12, 1, 0, -1);
        check_state("pre_rst", 0);
        check_state("pre_rst", 1);
        rx_n = 1'b0;
        idle(16 + 48 + 8);
        rst  = 1'b1;
        rx_n = 1'b1;
        idle(2);
        reset_model();
        check_state("mid_rst", 0);
        check_state("mid_rst", 1);
        check("mid_rst_data", 32'(rd_data_n), 32'h0);
        rst = 1'b0;
        idle(30);
        send_frame(0, 8'h3C, 1, 1, -1);
        check("post_rst_data", 32'(rd_data_n), 32'h3C);
        check_state("post_rst", 0);
        pop_one(0);

        // Randomised traffic on both channels
        for (int it = 0; it < 40; it++) begin
            int ch;
            ch = int'($urandom_range(0, 1));
            send_frame(ch, 8'($urandom), ($urandom_range(0, 9) != 0), ($urandom_range(0, 9) != 0), -1);
            check_state("rand_rx", ch);
            for (int p = 0; p < int'($urandom_range(0, 2)); p++) pop_one(int'($urandom_range(0, 1)));
            if ($urandom_range(0, 9) == 0) clear_errs();
            check_state("rand_n", 0);
            check_state("rand_e", 1);
            idle(int'($urandom_range(0, 5)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Parametrised RS232 receiver with a buffered read port. It replaces the single-register receive path behind the system's UART: serial `rx` is oversampled and framed with configurable data width and parity, then stored in a show-ahead FIFO. Framing, parity and overrun errors are reported as sticky flags. The uPC side reads bytes at its own pace, so no received data is lost between reads.

## Interface
- `CLK_HZ`, default 50_000_000: main clock frequency in Hz.
- `BAUD`, default 115_200: line rate.
- `DATA_BITS`, default 8: data bits per frame, legal range 5..8.
- `PARITY`, default 0: 0 = none, 1 = odd, 2 = even.
- `DEPTH`, default 16: FIFO entries, power of two, at least 2.
- `clk`, in, 1: main clock. Single clock domain.
- `rst`, in, 1: reset, synchronous, active-high.
- `rx`, in, 1: RS232 serial input, asynchronous, idle high.
- `rd_en`, in, 1: pop the head entry; ignored when `rd_valid`=0.
- `rd_data`, out, DATA_BITS: head entry, valid while `rd_valid`=1.
- `rd_valid`, out, 1: FIFO not empty.
- `count`, out, $clog2(DEPTH)+1: number of stored entries.
- `err_clr`, in, 1: clears all sticky error flags.
- `frame_err`, out, 1: sticky; a stop bit was sampled low.
- `parity_err`, out, 1: sticky; parity mismatch.
- `overrun`, out, 1: sticky; a frame completed while the FIFO was full.

## Operation
- **Synchroniser:** `rx` passes through two flops (reset to 1) before any use.
- **Oversample tick:**
  - Counter generates a one-cycle `tick` every DIV = CLK_HZ/(BAUD*16) clocks.
  - DIV is computed at elaboration and must be at least 1.
  - The counter wraps from DIV-1 to 0 and runs continuously.
- **Receive FSM:** states IDLE, START, DATA, PAR, STOP. It advances only on `tick`. A 4-bit tick counter gives bit timing.
  - IDLE: synced `rx`=0 → START, with the tick counter cleared.
  - START: after 8 ticks (mid start bit), sample `rx`.
    - `rx`=1 (glitch) → IDLE, nothing written.
    - `rx`=0 → DATA.
  - DATA: sample every 16 ticks, LSB first, into a shift register. After DATA_BITS samples → PAR if PARITY≠0, otherwise → STOP.
  - PAR: sample once after 16 ticks. Expected parity is the XOR of the data bits, inverted for odd. Mismatch latches a local `perr`. → STOP.
  - STOP: sample after 16 ticks, then → IDLE.
- **Frame result at the STOP sample:**
  - Stop bit=0: set `frame_err` and discard the byte.
  - Else if `perr`: set `parity_err` and discard the byte.
  - Else: push the byte to the FIFO.
- **FIFO push:**
  - If full and no pop in the same cycle: drop the byte and set `overrun`. The FIFO is unchanged.
  - If full and a pop in the same cycle: the push is accepted, `count` is unchanged, no overrun.
- **FIFO pop:** `rd_en` && `rd_valid` advances the read pointer. `rd_data` shows the next entry in the following cycle.
- **Simultaneous push and pop when empty:** the push is accepted and the pop is ignored (`rd_valid` was 0).
- **Pointers:** wrap modulo DEPTH. An extra MSB distinguishes full from empty.
- **Error flags:**
  - `err_clr` has priority over a same-cycle set; the event that cycle is lost.
  - Flags never affect FIFO contents.
- **Reset mid-frame:** an in-progress frame is abandoned, FSM → IDLE, FIFO emptied.

## Timing
- **Reset values:**
  - `rd_valid`=0, `count`=0, `rd_data`=0.
  - All error flags 0.
  - FSM IDLE, tick counter 0.
- **Receive latency:**
  - Push occurs on the clock edge at the STOP-sample `tick`.
  - `rd_valid`/`count` update one cycle later (registered).
  - `rd_data` is valid in the same cycle `rd_valid` rises.
- **Input latency:** 2 clocks of synchroniser delay from `rx` pin to FSM.
- **Sustained rate:** back-to-back frames are accepted. A start edge is detected in the first IDLE tick after STOP.
- **Error flag timing:** flags assert the cycle after the STOP-sample edge.
- **`count`:** updates the cycle after a push/pop edge. A simultaneous push and pop leaves it unchanged.

## Structure
- **Shared package `uart_pkg`:**
  - Parity mode constants: PAR_NONE=0, PAR_ODD=1, PAR_EVEN=2.
  - Receive FSM state encoding.
  - Function `uart_div(clk_hz, baud)` returning DIV.
- **Sub-module `sync_fifo`:**
  - Parameters WIDTH and DEPTH.
  - Ports: push, pop, din, dout, empty, full, count.
  - Show-ahead register-array FIFO.
- **Top level:** instantiates `sync_fifo` once. Synchroniser, tick generator and receive FSM are in the top level.

## Test plan
All scenarios use CLK_HZ=1_600_000, BAUD=100_000 (DIV=1, 16 clocks/bit), DEPTH=4.
- **8N1 single frame:** send 0xA5 → `rd_valid`=1 one clock after the stop sample, `rd_data`=0xA5, `count`=1. `rd_en` pulse → `rd_valid`=0.
- **Even parity:** PARITY=2, send 0x03 with parity bit 0 → stored. Send 0x03 with parity bit 1 → not stored, `parity_err`=1. `err_clr` → 0.
- **Framing error and glitch:**
  - Send 0x55 with stop bit 0 → `frame_err`=1, `count` unchanged.
  - 4-clock low glitch on `rx` → no frame, no flag.
- **Overrun:** send 5 frames 0x01..0x05 without reading → `count`=4, `overrun`=1. Reads return 0x01..0x04.
- **Full with pop on the push cycle:** FIFO full, `rd_en` held on the push cycle → byte accepted, `count`=4, `overrun`=0.
- **Reset mid-frame:** assert `rst` during data bit 3 → all outputs at reset values. The next full frame 0x3C is received correctly.
